load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store unit between the core datapath's ALU result/store data outputs and a handshaked data memory port. It handles byte/halfword/word lane steering, load sign/zero extension, and a req/ack memory handshake with timeout. It holds the core with `Stall` until the access completes. The load result it returns feeds the datapath's result-select path as `ReadData`.

## Interface
Parameters:
- `TIMEOUT`, 255: max `ACCESS` cycles waiting for `mem_ack` before fault (1..255).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `MemRead` in 1: current instruction is a load.
- `MemWrite` in 1: current instruction is a store; wins if both are set.
- `Funct3` in 3: size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- `ALUResult` in 32: effective byte address.
- `WriteData` in 32: store data (rs2).
- `ReadData` out 32: extended load result.
- `Stall` out 1: freeze PC and register write.
- `Fault` out 1: one-cycle pulse on misalign, timeout or illegal `Funct3`.
- `FaultAddr` out 32: address of last faulting access.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables (write only; 0 on reads).
- `mem_rdata` in 32: read word, valid with `mem_ack`.
- `mem_ack` in 1: access complete.

## Operation
FSM states: `IDLE`, `ACCESS`, `RESP`, `FAULT`.

- **IDLE**
  - `MemRead|MemWrite` → `Stall`=1 combinationally.
  - Register addr, `Funct3`, `we`, store data, byte enables.
  - Legal request → `ACCESS`. Illegal `Funct3` or misaligned (see Configuration) → `FAULT`.
- **ACCESS**
  - `mem_req`=1; `mem_we`/`mem_addr`/`mem_wdata`/`mem_be` come from registers and stay stable until ack.
  - `Stall`=1.
  - `mem_ack` → capture `mem_rdata`, go to `RESP`.
  - Timeout counter increments each cycle without ack; when it reaches `TIMEOUT` → `FAULT` with `mem_req` dropped.
- **RESP**
  - `Stall`=0; `ReadData` valid. The core retires the instruction at this clock edge.
  - Go to `IDLE`; the next instruction is sampled there.
- **FAULT**
  - `Fault`=1 and `Stall`=0 for one cycle; `ReadData`=0.
  - `FaultAddr` ← registered addr; go to `IDLE`.

Store steering:
- SB: byte replicated ×4, `mem_be` = `4'b0001 << addr[1:0]`.
- SH: half replicated ×2, `mem_be` = `0011` or `1100` by `addr[1]`.
- SW: `mem_be` = `1111`.

Load extraction:
- Lane selected by registered `addr[1:0]`.
- B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.

Other rules:
- Illegal `Funct3`: 011, 110, 111 for all accesses; also 100 and 101 on stores.
- `mem_ack` outside `ACCESS` is ignored.
- `reset` low, including mid-access: immediately state=`IDLE`; all outputs and registers are 0, including `FaultAddr`. A pending memory transaction is abandoned.

## Timing
- Load/store with ack in first `ACCESS` cycle: 3 cycles (`IDLE`, `ACCESS`, `RESP`), `Stall` high for 2.
- Each extra ack wait adds 1 cycle.
- Timeout path: `IDLE` + `TIMEOUT` `ACCESS` cycles + 1 `FAULT` cycle.
- Misaligned or illegal-`Funct3` path: 2 cycles (`IDLE`, `FAULT`), with no `mem_req`.
- `ReadData` is registered and held from `RESP` until the next capture or fault.
- Timeout counter is 8-bit, cleared on entry to `ACCESS`, and never wraps (`TIMEOUT` ≤ 255).

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - H/HU at `addr[0]`=1, or W at `addr[1:0]`≠0 → `FAULT`.
  - No memory request is issued.
- Undefined:
  - No misalignment faults.
  - H uses `addr[1]` and ignores `addr[0]`; W ignores `addr[1:0]`.
  - The access proceeds normally.

## Test plan
- **LB sign-extend:** LB at 0x103, `mem_rdata`=0x80FF_1234, ack in 1st cycle → `ReadData`=0xFFFF_FF80 in cycle 3, `Stall` high cycles 1–2 only.
- **SH upper half:** SH at 0x202, `WriteData`=0x0000_ABCD → `mem_addr`=0x200, `mem_be`=1100, `mem_wdata`=0xABCD_ABCD, `mem_we`=1 held stable through 4 wait cycles.
- **LHU zero-extend:** LHU at 0x0 with `mem_rdata`=0x1234_8001 → `ReadData`=0x0000_8001.
- **Timeout:** `TIMEOUT`=4, no ack → `mem_req` high exactly 4 cycles, then `Fault` pulse, `ReadData`=0, `FaultAddr`=address.
- **Misalignment:** LW at 0x06 → with `LSU_MISALIGN_TRAP_EN`, `Fault` at cycle 2 and no `mem_req`. Without it, `mem_addr`=0x04 and the access completes.
- **Reset mid-access:** `reset` low during `ACCESS` → `mem_req`/`Stall` drop asynchronously. After release, a new LW completes in 3 cycles.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: lane steering, load extension, req/ack memory handshake with timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of truncating the address.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic [31:0] FaultAddr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic [31:0] fault_addr_q;

  logic req_valid;
  logic req_illegal;
  logic req_misalign;

  function automatic logic [31:0] steer_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   steer_wdata = {4{wd[7:0]}};
      2'b01:   steer_wdata = {2{wd[15:0]}};
      default: steer_wdata = wd;
    endcase
  endfunction

  function automatic logic [3:0] steer_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   steer_be = 4'b0001 << a;
      2'b01:   steer_be = a[1] ? 4'b1100 : 4'b0011;
      default: steer_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  extract_load = {{24{b[7]}}, b};
      3'b001:  extract_load = {{16{h[15]}}, h};
      3'b100:  extract_load = {24'd0, b};
      3'b101:  extract_load = {16'd0, h};
      default: extract_load = rd;
    endcase
  endfunction

  // Request decode: legality of Funct3 for the access direction and optional alignment trap.
  always_comb begin
    req_valid = MemRead | MemWrite;
    case (Funct3)
      3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
      3'b100, 3'b101:         req_illegal = MemWrite;
      default:                req_illegal = 1'b1;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    case (Funct3[1:0])
      2'b01:   req_misalign = ALUResult[0];
      2'b10:   req_misalign = |ALUResult[1:0];
      default: req_misalign = 1'b0;
    endcase
`else
    req_misalign = 1'b0;
`endif
  end

  // Access sequencer; ReadData only changes on a load ack or a fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      funct3_q     <= 3'd0;
      we_q         <= 1'b0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      cnt_q        <= 8'd0;
      rdata_q      <= 32'd0;
      fault_addr_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= ALUResult;
            funct3_q <= Funct3;
            we_q     <= MemWrite;
            wdata_q  <= MemWrite ? steer_wdata(Funct3, WriteData) : 32'd0;
            be_q     <= MemWrite ? steer_be(Funct3, ALUResult[1:0]) : 4'd0;
            cnt_q    <= 8'd0;
            if (req_illegal || req_misalign) begin
              state_q      <= FAULT;
              fault_addr_q <= ALUResult;
              rdata_q      <= 32'd0;
            end else begin
              state_q <= ACCESS;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!we_q) begin
              rdata_q <= extract_load(funct3_q, addr_q[1:0], mem_rdata);
            end else begin
              rdata_q <= rdata_q;
            end
            state_q <= RESP;
          end else if ((cnt_q + 8'd1) >= TIMEOUT_C) begin
            state_q      <= FAULT;
            fault_addr_q <= addr_q;
            rdata_q      <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP:    state_q <= IDLE;
        FAULT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall is raised combinationally on a new request so the core freezes in the issue cycle.
  assign Stall     = reset & (((state_q == IDLE) & req_valid) | (state_q == ACCESS));
  assign mem_req   = (state_q == ACCESS);
  assign Fault     = (state_q == FAULT);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign ReadData  = rdata_q;
  assign FaultAddr = fault_addr_q;

endmodule
